// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel level-to-pulse converter.
// Each channel synchronises an async level, detects rise/fall/both edges,
// stretches each detection into a PULSE_LEN-cycle registered pulse, and
// keeps a sticky "edge seen" flag plus a saturating event counter.
module multi_edge_pulse_gen #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         lvl_sig,
    input  logic [CH-1:0]         en,
    input  logic [CH-1:0]         sticky_clr,
    input  logic                  cnt_clr,
    output logic [CH-1:0]         pulse_sig,
    output logic [CH-1:0]         edge_sticky,
    output logic [CH*CNT_W-1:0]   evt_cnt
);

    localparam int               SW        = $clog2(PULSE_LEN + 1);
    localparam logic [SW-1:0]    LOAD_VAL  = SW'(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   hist_reg;
            logic                   rise;
            logic                   fall;
            logic                   det;
            logic [SW-1:0]          stretch_reg;
            logic [SW-1:0]          stretch_next;
            logic                   pulse_reg;
            logic                   sticky_reg;
            logic [CNT_W-1:0]       cnt_reg;

            // Synchroniser chain plus one history flop; runs regardless of en
            // so re-enabling never sees stale history.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '0;
                    hist_reg <= 1'b0;
                end else begin
                    sync_reg[0] <= lvl_sig[gi];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= sync_reg[k-1];
                    end
                    hist_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            // Edge detection on the synchronised level, selected by MODE and gated by en.
            always_comb begin
                rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;
                fall = ~sync_reg[SYNC_STAGES-1] & hist_reg;
                det  = 1'b0;
                case (MODE)
                    0:       det = rise;
                    1:       det = fall;
                    default: det = rise | fall;
                endcase
                det = det & en[gi];
            end

            // Next stretch count: disable clears, detection (re)loads, else count down.
            always_comb begin
                stretch_next = stretch_reg;
                if (!en[gi]) begin
                    stretch_next = '0;
                end else if (det) begin
                    stretch_next = LOAD_VAL;
                end else if (stretch_reg != '0) begin
                    stretch_next = stretch_reg - SW'(1);
                end
            end

            // Stretch counter and registered pulse; pulse mirrors a non-zero count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stretch_reg <= '0;
                    pulse_reg   <= 1'b0;
                end else begin
                    stretch_reg <= stretch_next;
                    pulse_reg   <= (stretch_next != '0);
                end
            end

            // Sticky flag: a detection in the same cycle as a clear wins.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sticky_reg <= 1'b0;
                end else if (det) begin
                    sticky_reg <= 1'b1;
                end else if (sticky_clr[gi]) begin
                    sticky_reg <= 1'b0;
                end
            end

            // Saturating event counter; a clear coincident with a detection leaves 1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= det ? CNT_W'(1) : '0;
                end else if (det && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign pulse_sig[gi]                 = pulse_reg;
            assign edge_sticky[gi]               = sticky_reg;
            assign evt_cnt[gi*CNT_W +: CNT_W]    = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Randomised scoreboard bench for multi_edge_pulse_gen.
// The reference model works on the history of sampled levels per clock edge
// and on "last detection / last kill" edge numbers rather than on counters.
module tb_multi_edge_pulse_gen;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int MD   = 2;
    localparam int PL   = 3;
    localparam int CW   = 3;
    localparam int NVEC = 3000;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     lvl_sig;
    logic [CH-1:0]     en;
    logic [CH-1:0]     sticky_clr;
    logic              cnt_clr;
    logic [CH-1:0]     pulse_sig;
    logic [CH-1:0]     edge_sticky;
    logic [CH*CW-1:0]  evt_cnt;

    always #5 clk = ~clk;

    multi_edge_pulse_gen #(
        .CH(CH), .SYNC_STAGES(SS), .MODE(MD), .PULSE_LEN(PL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .lvl_sig(lvl_sig), .en(en),
        .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
        .pulse_sig(pulse_sig), .edge_sticky(edge_sticky), .evt_cnt(evt_cnt)
    );

    typedef struct packed {
        int               idx;
        logic [CH-1:0]    pulse;
        logic [CH-1:0]    sticky;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int edge_cnt    = 0;
    int vectors     = 0;
    int miscompares = 0;

    always @(posedge clk) edge_cnt++;

    // Reference model state
    logic [CH-1:0] samp [0:NVEC+16];
    int            last_det  [CH];
    int            last_kill [CH];
    logic [CH-1:0] m_sticky;
    int            m_cnt     [CH];

    // Stimulus + model: inputs change on the falling edge, the expected state
    // after the next rising edge is pushed onto the scoreboard.
    initial begin
        exp_t e;
        int   m;
        logic nw, od, d;
        for (int i = 0; i <= NVEC + 16; i++) samp[i] = '0;
        for (int c = 0; c < CH; c++) begin
            last_det[c] = -100; last_kill[c] = 0; m_cnt[c] = 0;
        end
        m_sticky   = '0;
        rst        = 1'b1;
        lvl_sig    = '0;
        en         = '1;
        sticky_clr = '0;
        cnt_clr    = 1'b0;
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            m = edge_cnt + 1;
            rst = (v < 4) || ($urandom_range(0, 149) == 0);
            for (int c = 0; c < CH; c++) begin
                // channel c flips with probability 1/(2^(c+1)) roughly
                if ($urandom_range(0, (2 << c) - 1) == 0) lvl_sig[c] = ~lvl_sig[c];
                en[c]         = ($urandom_range(0, 9) != 0);
                sticky_clr[c] = ($urandom_range(0, 9) == 0);
            end
            cnt_clr = ($urandom_range(0, 29) == 0);

            if (rst) begin
                // reset wipes the newest SS+1 samples held in the chain
                for (int j = 0; j <= SS; j++) if (m - j >= 0) samp[m-j] = '0;
                for (int c = 0; c < CH; c++) begin
                    last_kill[c] = m; m_cnt[c] = 0;
                end
                m_sticky = '0;
            end else begin
                samp[m] = lvl_sig;
                for (int c = 0; c < CH; c++) begin
                    nw = (m - SS >= 0)     ? samp[m-SS][c]   : 1'b0;
                    od = (m - SS - 1 >= 0) ? samp[m-SS-1][c] : 1'b0;
                    case (MD)
                        0:       d = nw & ~od;
                        1:       d = ~nw & od;
                        default: d = nw ^ od;
                    endcase
                    d = d & en[c];
                    if (!en[c]) last_kill[c] = m;
                    if (d) last_det[c] = m;
                    if (d) m_sticky[c] = 1'b1;
                    else if (sticky_clr[c]) m_sticky[c] = 1'b0;
                    if (cnt_clr) m_cnt[c] = d ? 1 : 0;
                    else if (d && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
                end
            end

            e.idx    = m;
            e.sticky = m_sticky;
            for (int c = 0; c < CH; c++) begin
                e.pulse[c] = (last_det[c] > last_kill[c]) && (m - last_det[c] < PL);
                e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
            end
            sb.push_back(e);
        end
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: after each rising edge, compare every scoreboard entry due by now.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].idx <= edge_cnt) begin
                e = sb.pop_front();
                vectors++;
                if (pulse_sig !== e.pulse) begin
                    $display("FAIL pulse edge %0d: got %b required %b", e.idx, pulse_sig, e.pulse);
                    miscompares++;
                end
                if (edge_sticky !== e.sticky) begin
                    $display("FAIL sticky edge %0d: got %b required %b", e.idx, edge_sticky, e.sticky);
                    miscompares++;
                end
                if (evt_cnt !== e.cnt) begin
                    $display("FAIL evt_cnt edge %0d: got %h required %h", e.idx, evt_cnt, e.cnt);
                    miscompares++;
                end
            end
        end
    end

endmodule
